// File: rtl/mdr_mem_port.sv
// Memory data register with request/ready handshake, byte/half/word loads and store byte enables.
// Define MDR_TIMEOUT_EN to abort stalled transfers after TIMEOUT wait cycles and raise err.
module mdr_mem_port #(
    parameter int DATA_W  = 32,
    parameter int LANE_W  = 2,
    parameter int TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  Clear_n,
    input  logic [DATA_W-1:0]     BusMuxOut,
    input  logic                  MDRIn,
    input  logic                  MDRead,
    input  logic                  MDWrite,
    input  logic [1:0]            Size,
    input  logic                  Signed,
    input  logic [LANE_W-1:0]     ByteSel,
    input  logic [DATA_W-1:0]     Mem_rdata,
    input  logic                  Mem_ready,
    output logic                  Mem_req,
    output logic                  Mem_we,
    output logic [DATA_W/8-1:0]   Mem_be,
    output logic [DATA_W-1:0]     Mem_wdata,
    output logic [DATA_W-1:0]     Q,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int NB = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2
    } state_t;

    state_t              state_q;
    logic [DATA_W-1:0]   data_q;
    logic [1:0]          size_q;
    logic                signed_q;
    logic [LANE_W-1:0]   lane_q;
    logic [NB-1:0]       be_q;
    logic                we_q;
    logic                done_q;
    logic                err_q;

    logic [NB-1:0]       be_d;
    logic [LANE_W-1:0]   rdLane_d;
    logic [7:0]          byteVal_d;
    logic [15:0]         halfVal_d;
    logic [DATA_W-1:0]   load_d;
    logic                expire_d;

`ifdef MDR_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q;

    // Counts wait cycles without Mem_ready; held at zero whenever no transfer is pending.
    always_ff @(posedge clk) begin
        if (!Clear_n) begin
            cnt_q <= '0;
        end else if (state_q == IDLE) begin
            cnt_q <= '0;
        end else if (!Mem_ready) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign expire_d = (cnt_q == CNT_W'(TIMEOUT - 1));
`else
    // Without the counter a pending transfer never expires.
    assign expire_d = 1'b0 && (TIMEOUT > 0);
`endif

    // Store byte enables: halves always sit on an even lane pair.
    always_comb begin
        be_d = '0;
        case (Size)
            2'b00:   be_d = NB'(1) << ByteSel;
            2'b01:   be_d = NB'(3) << (ByteSel & ~LANE_W'(1));
            default: be_d = '1;
        endcase
    end

    always_comb begin
        rdLane_d  = (size_q == 2'b01) ? (lane_q & ~LANE_W'(1)) : lane_q;
        byteVal_d = 8'(Mem_rdata >> {rdLane_d, 3'b000});
        halfVal_d = 16'(Mem_rdata >> {rdLane_d, 3'b000});
        load_d    = Mem_rdata;
        case (size_q)
            2'b00:   load_d = {{(DATA_W-8){signed_q & byteVal_d[7]}}, byteVal_d};
            2'b01:   load_d = {{(DATA_W-16){signed_q & halfVal_d[15]}}, halfVal_d};
            default: load_d = Mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!Clear_n) begin
            state_q  <= IDLE;
            data_q   <= '0;
            size_q   <= 2'b00;
            signed_q <= 1'b0;
            lane_q   <= '0;
            be_q     <= '0;
            we_q     <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (MDRead) begin
                        state_q  <= RD_WAIT;
                        size_q   <= Size;
                        signed_q <= Signed;
                        lane_q   <= ByteSel;
                        we_q     <= 1'b0;
                        be_q     <= '0;
                        err_q    <= 1'b0;
                    end else if (MDWrite) begin
                        state_q  <= WR_WAIT;
                        size_q   <= Size;
                        lane_q   <= ByteSel;
                        we_q     <= 1'b1;
                        be_q     <= be_d;
                        err_q    <= 1'b0;
                    end else if (MDRIn) begin
                        data_q   <= BusMuxOut;
                    end
                end
                RD_WAIT: begin
                    if (Mem_ready) begin
                        data_q  <= load_d;
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end else if (expire_d) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                    end
                end
                WR_WAIT: begin
                    // A ready on the expiry edge still counts as a normal completion.
                    if (Mem_ready || expire_d) begin
                        state_q <= IDLE;
                        we_q    <= 1'b0;
                        be_q    <= '0;
                        done_q  <= 1'b1;
                        err_q   <= !Mem_ready;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign Mem_req   = (state_q != IDLE);
    assign busy      = (state_q != IDLE);
    assign Mem_we    = we_q;
    assign Mem_be    = be_q;
    assign Mem_wdata = data_q;
    assign Q         = data_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule
